// File: rtl/strobe_packetizer_pkg.sv
// Shared types and helpers for the strobe packetizer and related capture stages.
package strobe_pkt_pkg;

  typedef enum logic [1:0] {
    StWaitBuf,
    StFill,
    StDone
  } state_e;

  localparam int unsigned WordBytes = 4;

  // Word count carries one extra bit so a full packet is representable.
  function automatic int unsigned byte_len_width(input int unsigned addr_width);
    return addr_width + 1 + $clog2(WordBytes);
  endfunction

endpackage

// File: rtl/strobe_packetizer_idle_timer.sv
// Idle-cycle counter: clear has priority, saturates at Timeout, tc_o flags the edge that reaches it.
module idle_timer #(
  parameter int unsigned Timeout = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(Timeout + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CntW'(Timeout))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tc_o = inc_i && !clr_i && (cnt_d == CntW'(Timeout));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/strobe_packetizer.sv
// Packs a strobed 32-bit word stream into packet buffers, closing on full or idle timeout.
// Optional statistics counters are enabled with the STROBE_PKT_STATS_EN macro.
module strobe_packetizer
  import strobe_pkt_pkg::*;
#(
  parameter int unsigned PKT_WORDS    = 16,
  parameter int unsigned ADDR_WIDTH   = $clog2(PKT_WORDS),
  parameter int unsigned IDLE_TIMEOUT = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [31:0]                           data,
  input  logic                                  strobe,
  input  logic                                  buf_ready,
  output logic                                  wr_en,
  output logic [ADDR_WIDTH-1:0]                 wr_addr,
  output logic [31:0]                           wr_data,
  output logic                                  done,
  output logic [byte_len_width(ADDR_WIDTH)-1:0] byte_len,
  output logic                                  dropped
`ifdef STROBE_PKT_STATS_EN
  ,
  output logic [31:0]                           pkt_count,
  output logic [31:0]                           drop_count
`endif
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam int unsigned LenW = byte_len_width(ADDR_WIDTH);

  state_e                state_q, state_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  idle_clr, idle_inc, idle_tc;
  logic                  wr_en_d, dropped_d;
  logic [LenW-1:0]       byte_len_d;

  logic                  wr_en_q, done_q, dropped_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [31:0]           wr_data_q;
  logic [LenW-1:0]       byte_len_q;

  idle_timer #(
    .Timeout(IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (idle_clr),
    .inc_i (idle_inc),
    .tc_o  (idle_tc)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_en_d    = 1'b0;
    dropped_d  = 1'b0;
    idle_clr   = 1'b1;
    idle_inc   = 1'b0;
    byte_len_d = '0;
    unique case (state_q)
      StWaitBuf: begin
        if (strobe) begin
          if (buf_ready) begin
            wr_en_d = 1'b1;
            count_d = CntW'(1);
            state_d = StFill;
          end else begin
            dropped_d = 1'b1;
          end
        end
      end
      StFill: begin
        idle_clr = strobe;
        idle_inc = !strobe;
        if (strobe) begin
          wr_en_d = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == CntW'(PKT_WORDS - 1)) begin
            state_d = StDone;
          end
        end else if (idle_tc) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // The packet is closed; a word arriving now has nowhere to go.
        dropped_d  = strobe;
        byte_len_d = LenW'(count_q) * LenW'(WordBytes);
        count_d    = '0;
        state_d    = StWaitBuf;
      end
      default: state_d = StWaitBuf;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StWaitBuf;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      byte_len_q <= '0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      done_q     <= (state_q == StDone);
      byte_len_q <= byte_len_d;
      dropped_q  <= dropped_d;
      if (wr_en_d) begin
        wr_addr_q <= count_q[ADDR_WIDTH-1:0];
        wr_data_q <= data;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign byte_len = byte_len_q;
  assign dropped  = dropped_q;

`ifdef STROBE_PKT_STATS_EN
  logic [31:0] pkt_count_q, drop_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (done_q && (pkt_count_q != '1)) begin
        pkt_count_q <= pkt_count_q + 1'b1;
      end
      if (dropped_q && (drop_count_q != '1)) begin
        drop_count_q <= drop_count_q + 1'b1;
      end
    end
  end

  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_strobe_packetizer.sv
// Self-checking bench for strobe_packetizer: packet-level reference model plus directed and random stimulus.
module tb_strobe_packetizer;

  localparam int unsigned PW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 64;
  localparam int unsigned LW = AW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   data = '0;
  logic          strobe = 1'b0;
  logic          buf_ready = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          done;
  logic [LW-1:0] byte_len;
  logic          dropped;
`ifdef STROBE_PKT_STATS_EN
  logic [31:0]   pkt_count;
  logic [31:0]   drop_count;
`endif

  strobe_packetizer #(
    .PKT_WORDS   (PW),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .strobe    (strobe),
    .buf_ready (buf_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .done      (done),
    .byte_len  (byte_len),
    .dropped   (dropped)
`ifdef STROBE_PKT_STATS_EN
    ,
    .pkt_count (pkt_count),
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the open packet as a word count and a quiet-cycle count,
  // and predicts the outputs visible in the cycle after each clock edge.
  bit          m_open, m_closing;
  int          m_n, m_quiet;
  bit          e_wr_en, e_done, e_dropped;
  int          e_addr, e_len;
  logic [31:0] e_data;
  logic [31:0] e_pkt, e_drop;
  time         last_strobe_t;

  always @(posedge clk) begin
    if (!rst) begin
      m_open = 0; m_closing = 0; m_n = 0; m_quiet = 0;
      e_wr_en = 0; e_done = 0; e_dropped = 0; e_addr = 0; e_len = 0; e_data = '0;
      e_pkt = '0; e_drop = '0;
    end else begin
      if (e_done) e_pkt = e_pkt + 1;
      if (e_dropped) e_drop = e_drop + 1;
      e_wr_en = 0; e_done = 0; e_dropped = 0; e_len = 0;
      if (strobe) last_strobe_t = $time;
      if (m_closing) begin
        e_done = 1; e_len = m_n * 4; e_dropped = strobe;
        m_closing = 0; m_open = 0; m_n = 0;
      end else if (!m_open && strobe && !buf_ready) begin
        e_dropped = 1;
      end else if (strobe) begin
        m_open = 1;
        e_wr_en = 1; e_addr = m_n; e_data = data;
        m_n++; m_quiet = 0;
        if (m_n == PW) m_closing = 1;
      end else if (m_open) begin
        m_quiet++;
        if (m_quiet == TO) m_closing = 1;
      end
    end
  end

  // Observation counters, read by the directed scenarios as deltas.
  int          obs_wr = 0, obs_done = 0, obs_drop = 0;
  time         last_wr_t, done_t;
  logic [31:0] last_wr_data;
  logic [LW-1:0] obs_len;

  always @(negedge clk) begin
    if (rst) begin
      check("wr_en", wr_en, e_wr_en);
      if (e_wr_en) begin
        check("wr_addr", wr_addr, e_addr[AW-1:0]);
        check("wr_data", wr_data, e_data);
      end
      check("done", done, e_done);
      if (e_done) check("byte_len", byte_len, e_len);
      check("dropped", dropped, e_dropped);
`ifdef STROBE_PKT_STATS_EN
      check("pkt_count", pkt_count, e_pkt);
      check("drop_count", drop_count, e_drop);
`endif
      if (wr_en) begin obs_wr++; last_wr_t = $time; last_wr_data = wr_data; end
      if (done) begin obs_done++; done_t = $time; obs_len = byte_len; end
      if (dropped) obs_drop++;
    end
  end

  task automatic drive(input bit s, input logic [31:0] d, input bit br);
    @(negedge clk);
    strobe = s; data = d; buf_ready = br;
  endtask

  task automatic idle(input int n, input bit br);
    for (int i = 0; i < n; i++) drive(1'b0, '0, br);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    strobe = 0; buf_ready = 0;
    rst = 0;
    #1;
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, '0);
    check("rst_wr_data", wr_data, '0);
    check("rst_done", done, 1'b0);
    check("rst_byte_len", byte_len, '0);
    check("rst_dropped", dropped, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1;
  endtask

  int b_wr, b_done, b_drop;

  task automatic mark();
    settle();
    b_wr = obs_wr; b_done = obs_done; b_drop = obs_drop;
  endtask

  task automatic full_packet(input string tag);
    mark();
    for (int i = 0; i < 16; i++) drive(1'b1, 32'h1000 + i, 1'b1);
    idle(4, 1'b1);
    settle();
    check({tag, "_writes"}, obs_wr - b_wr, 16);
    check({tag, "_dones"}, obs_done - b_done, 1);
    check({tag, "_len"}, obs_len, 64);
    check({tag, "_drops"}, obs_drop - b_drop, 0);
    check({tag, "_done_after_write"}, done_t - last_wr_t, 10);
  endtask

  initial begin
    #3;
    do_reset();

    full_packet("full");

    // Idle timeout: T quiet cycles counted, then the DONE cycle, then the registered pulse.
    do_reset();
    mark();
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h5000 + i, 1'b1);
    idle(80, 1'b1);
    settle();
    check("to_writes", obs_wr - b_wr, 5);
    check("to_dones", obs_done - b_done, 1);
    check("to_len", obs_len, 20);
    check("to_delay", done_t - last_strobe_t, (TO + 1) * 10 + 5);

    // No buffer available.
    do_reset();
    mark();
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h7000 + i, 1'b0);
    idle(3, 1'b0);
    settle();
    check("nobuf_writes", obs_wr - b_wr, 0);
    check("nobuf_drops", obs_drop - b_drop, 3);
    drive(1'b1, 32'hABCD, 1'b1);
    idle(2, 1'b1);
    settle();
    check("nobuf_late_write", obs_wr - b_wr, 1);
    check("nobuf_late_data", last_wr_data, 32'hABCD);
    idle(75, 1'b0);

    // Back-to-back packets.
    do_reset();
    mark();
    for (int i = 0; i < 40; i++) drive(1'b1, 32'h2000 + i, 1'b1);
    idle(3, 1'b1);
    settle();
    check("b2b_writes", obs_wr - b_wr, 38);
    check("b2b_dones", obs_done - b_done, 2);
    check("b2b_drops", obs_drop - b_drop, 2);
`ifdef STROBE_PKT_STATS_EN
    check("b2b_pkt_count", pkt_count, 2);
    check("b2b_drop_count", drop_count, 2);
`endif
    idle(75, 1'b1);
    settle();
    check("b2b_tail_len", obs_len, 24);

    // Asynchronous reset mid-packet.
    do_reset();
    mark();
    for (int i = 0; i < 7; i++) drive(1'b1, 32'h3000 + i, 1'b1);
    @(posedge clk);
    #3;
    check("mid_wr_en_before", wr_en, 1'b1);
    strobe = 0;
    rst = 0;
    #1;
    check("mid_wr_en", wr_en, 1'b0);
    check("mid_wr_data", wr_data, '0);
    check("mid_done", done, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1;
    idle(TO + 10, 1'b1);
    settle();
    check("mid_no_done", obs_done - b_done, 0);
    full_packet("after_rst");

    // Randomized phases of varying strobe density and buffer availability.
    do_reset();
    for (int p = 0; p < 45; p++) begin
      int dens, rdy, len;
      dens = $urandom_range(0, 100);
      rdy  = $urandom_range(0, 100);
      len  = $urandom_range(5, 90);
      if (p % 6 == 5) dens = 0;
      for (int c = 0; c < len; c++) begin
        drive($urandom_range(0, 99) < dens, $urandom, $urandom_range(0, 99) < rdy);
      end
    end
    idle(TO + 5, 1'b0);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
